serial_byte_tx: RTL and testbench

//  Parallel-in / serial-out transmitter; the sending end of our 8-bit serial-in shift-register link.

---
 rtl/ser_pkg.sv | 11 +
 rtl/serial_tx_shifter.sv | 31 +++
 rtl/serial_byte_tx.sv | 101 ++++++++++
 tb/tb_serial_byte_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and defaults for the serial byte transmitter.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH = 8;

endpackage : ser_pkg

// File: rtl/serial_tx_shifter.sv
// Load/shift register feeding the serial output. Shifts toward bit 0;
// q0 is the bit that goes out on the next shift step.
module serial_tx_shifter
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] r_q;

    // Load has priority so a back-to-back word replaces the drained one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign q0 = r_q[0];

endmodule : serial_tx_shifter

// File: rtl/serial_byte_tx.sv
// Parallel-in / serial-out transmitter, LSB first, one bit per clk,
// with a valid/ready input handshake and back-to-back frame support.
module serial_byte_tx
    import ser_pkg::*;
#(
    parameter int   WIDTH    = SER_WIDTH,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sen,
    output logic             busy,
    output logic             done
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    ser_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sout;
    logic            r_sen;
    logic            r_done;

    logic            w_last;
    logic            w_accept;
    logic            w_shift;
    logic            w_q0;
    logic [WIDTH-1:0] w_load_word;

    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
    assign din_ready = (r_state == IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;
    assign w_shift   = (r_state == SHIFT) && !w_last;

    // Bit 0 leaves directly via sout on the accepting edge, so the shifter
    // holds the word pre-shifted by one and q0 is always the next bit due.
    assign w_load_word = {1'b0, din[WIDTH-1:1]};

    serial_tx_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shift),
        .d     (w_load_word),
        .q0    (w_q0)
    );

    // Frame FSM: bit counter, registered serial output, enable and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sout  <= IDLE_LVL;
            r_sen   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_sout  <= din[0];
                        r_sen   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (!w_last) begin
                        r_sout <= w_q0;
                        r_cnt  <= r_cnt + CW'(1);
                    end else begin
                        // Last bit retires this edge; chain straight into a
                        // new frame if a word is offered, else fall idle.
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                        if (w_accept) begin
                            r_sout <= din[0];
                            r_sen  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_sout  <= IDLE_LVL;
                            r_sen   <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sout = r_sout;
    assign sen  = r_sen;
    assign done = r_done;
    assign busy = (r_state == SHIFT);

endmodule : serial_byte_tx

// File: tb/tb_serial_byte_tx.sv
// Directed bench: transmitter paired with a falling-edge serial-in receiver.
module tb_serial_byte_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sen;
    logic       busy;
    logic       done;

    logic [7:0] rx_q;
    int         errors;
    int         checks;

    serial_byte_tx #(.WIDTH(8), .IDLE_LVL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .sen       (sen),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver: samples on the falling edge, enters at MSB, shifts toward bit 0.
    always @(negedge clk) begin
        if (sen) rx_q <= {sout, rx_q[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one frame already accepted on the previous edge. Optionally
    // scribbles din with valid high from bit 2 (backpressure), then offers
    // nxt/nxt_vld at bit 7 so it is taken on the retiring edge.
    task automatic run_frame(input string tag, input logic [7:0] w, input logic first_done,
                             input logic bp, input logic [7:0] nxt, input logic nxt_vld);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_sout"},  sout, w[k]);
            chk({tag, "_sen"},   sen, 1'b1);
            chk({tag, "_busy"},  busy, 1'b1);
            chk({tag, "_done"},  done, (k == 0) ? first_done : 1'b0);
            chk({tag, "_ready"}, din_ready, (k == 7));
            if (bp && k >= 2 && k < 7) begin
                din       = 8'h7E ^ 8'(k);
                din_valid = 1'b1;
            end
            if (k == 7) begin
                din       = nxt;
                din_valid = nxt_vld;
            end
            tick();
            if (k == 7) din_valid = 1'b0;
        end
        chk({tag, "_rx"}, rx_q, w);
    endtask

    task automatic idle_tail(input string tag);
        chk({tag, "_done1"}, done, 1'b1);
        chk({tag, "_sen0"},  sen, 1'b0);
        chk({tag, "_sout0"}, sout, 1'b0);
        chk({tag, "_busy0"}, busy, 1'b0);
        chk({tag, "_rdy1"},  din_ready, 1'b1);
        tick();
        chk({tag, "_done0"}, done, 1'b0);
        chk({tag, "_sen_stay0"}, sen, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rx_q      = 8'h00;
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;

        // 1. reset, then idle
        tick();
        chk("rst_sout", sout, 1'b0);
        chk("rst_sen",  sen, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_sout", sout, 1'b0);
            chk("idle_sen",  sen, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_rdy",  din_ready, 1'b1);
        end

        // 2. single word
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        run_frame("a5", 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_tail("a5");

        // 3. back-to-back 3C then FF
        din = 8'h3C; din_valid = 1'b1;
        tick();
        run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1);
        run_frame("b2b_ff", 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
        idle_tail("b2b");

        // 4. backpressure: 01 with din churning, then 80
        din = 8'h01; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        run_frame("bp_01", 8'h01, 1'b0, 1'b1, 8'h80, 1'b1);
        run_frame("bp_80", 8'h80, 1'b1, 1'b0, 8'h00, 1'b0);
        idle_tail("bp");

        // 5. reset mid-frame on C3, after bit 3
        din = 8'hC3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_sout", sout, 1'(8'hC3 >> k));
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sout", sout, 1'b0);
        chk("mid_rst_sen",  sen, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_sen",  sen, 1'b0);
        end
        din = 8'h5A; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        run_frame("r5a", 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_tail("r5a");

        // 6. boundary words
        din = 8'h00; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        run_frame("z00", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_tail("z00");
        din = 8'hFF; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        run_frame("fff", 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_tail("fff");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_byte_tx
